iic_key_ctrl: RTL and testbench



---
 rtl/iic_key_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_iic_key_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_key_ctrl.sv
// iic_key_ctrl: push-button command front end for the EEPROM I2C master.
// Two bouncy active-low buttons are synchronised, debounced and edge-detected.
// Each accepted press produces one active-low strobe on key_rd or key_wr,
// followed by a lockout window. data_in advances after every issued write.
//
// Build option: define IIC_KEY_CMD_QUEUE_EN to keep one pending command
// that is captured during ISSUE/LOCK and launched once the lockout ends.
// With the macro undefined, presses during ISSUE/LOCK are dropped.
//
//  state | meaning
//  IDLE  | waiting for a press (or a pending command)
//  ISSUE | selected strobe held low for PULSE_CYCLES cycles
//  LOCK  | lockout for LOCKOUT_CYCLES cycles, busy still high
module iic_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 5000000,
  parameter logic [7:0]  DATA_INIT       = 8'h00,
  parameter logic [7:0]  DATA_STEP       = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_rd_raw,
  input  logic       key_wr_raw,
  output logic       key_rd,
  output logic       key_wr,
  output logic [7:0] data_in,
  output logic       busy
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned TM_MAX = (PULSE_CYCLES > LOCKOUT_CYCLES) ? PULSE_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TM_W   = $clog2(TM_MAX) + 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] PULSE_LOAD = TM_W'(PULSE_CYCLES - 1);
  localparam logic [TM_W-1:0] LOCK_LOAD  = TM_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, LOCK} state_t;

  // bit 0 = read key, bit 1 = write key
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      stable;
  logic [1:0]      stable_d;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state;
  logic            cmd_wr;
  logic [TM_W-1:0] tmr;
  logic            go;
  logic            go_wr;

`ifdef IIC_KEY_CMD_QUEUE_EN
  logic            pend_v;
  logic            pend_wr;
`endif

  assign raw   = {key_wr_raw, key_rd_raw};
  // stable level fell 1->0 on the previous edge; releases are ignored
  assign press = stable_d & ~stable;

  // Two-flop synchroniser for both raw keys
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= 2'b11;
      stable_d <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Launch decision in IDLE: pending command first, then a fresh press (read wins a tie)
  always_comb begin
    go    = 1'b0;
    go_wr = 1'b0;
    if (state == IDLE) begin
`ifdef IIC_KEY_CMD_QUEUE_EN
      if (pend_v) begin
        go    = 1'b1;
        go_wr = pend_wr;
      end else if (|press) begin
        go    = 1'b1;
        go_wr = ~press[0];
      end
`else
      if (|press) begin
        go    = 1'b1;
        go_wr = ~press[0];
      end
`endif
    end
  end

  // Command FSM with registered strobes, busy and write data
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_wr  <= 1'b0;
      tmr     <= '0;
      key_rd  <= 1'b1;
      key_wr  <= 1'b1;
      busy    <= 1'b0;
      data_in <= DATA_INIT;
`ifdef IIC_KEY_CMD_QUEUE_EN
      pend_v  <= 1'b0;
      pend_wr <= 1'b0;
`endif
    end else begin
`ifdef IIC_KEY_CMD_QUEUE_EN
      // only the first press of an ISSUE/LOCK window is remembered
      if (state != IDLE && !pend_v && |press) begin
        pend_v  <= 1'b1;
        pend_wr <= ~press[0];
      end
      if (state == IDLE && pend_v) pend_v <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (go) begin
            state  <= ISSUE;
            cmd_wr <= go_wr;
            key_rd <= go_wr;
            key_wr <= ~go_wr;
            busy   <= 1'b1;
            tmr    <= PULSE_LOAD;
          end
        end
        ISSUE: begin
          if (tmr == '0) begin
            key_rd <= 1'b1;
            key_wr <= 1'b1;
            state  <= LOCK;
            tmr    <= LOCK_LOAD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        LOCK: begin
          if (tmr == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            // data stays frozen for the whole transaction, advances only afterwards
            if (cmd_wr) data_in <= data_in + DATA_STEP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          key_rd <= 1'b1;
          key_wr <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_key_ctrl.sv
// Testbench for iic_key_ctrl (small debounce/pulse/lockout values).
// The reference model tracks, per key, how long the synced level has disagreed
// with the accepted level, and describes each issued command by its start edge.
module tb_iic_key_ctrl;
  localparam int D = 8;
  localparam int P = 2;
  localparam int L = 16;
`ifdef IIC_KEY_CMD_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_rd_raw = 1'b1;
  logic       key_wr_raw = 1'b1;
  logic       key_rd, key_wr, busy;
  logic [7:0] data_in;

  int n_cmp = 0;
  int n_err = 0;

  iic_key_ctrl #(
    .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .LOCKOUT_CYCLES(L),
    .DATA_INIT(8'h00), .DATA_STEP(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .key_rd_raw(key_rd_raw), .key_wr_raw(key_wr_raw),
    .key_rd(key_rd), .key_wr(key_wr), .data_in(data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         ec;
  bit [1:0]   m_s1, m_s2, m_stab, m_old;
  int         m_run [2];
  int         m_start, m_end;
  bit         m_cmd_wr, m_pend_v, m_pend_wr;
  logic [7:0] m_data;
  bit         in_pulse, exp_rd, exp_wr, exp_busy;

  always @(posedge clk) begin
    bit [1:0] pr;
    bit [1:0] raw;
    raw = {key_wr_raw, key_rd_raw};
    if (rst) begin
      ec = 0; m_s1 = 2'b11; m_s2 = 2'b11; m_stab = 2'b11; m_old = 2'b11;
      m_run[0] = 0; m_run[1] = 0;
      m_start = -1000; m_end = -1000;
      m_cmd_wr = 0; m_pend_v = 0; m_pend_wr = 0; m_data = 8'h00;
    end else begin
      ec++;
      pr = m_old & ~m_stab;
      m_old = m_stab;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin m_stab[i] = m_s2[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
      if (ec == m_end && m_cmd_wr) m_data = m_data + 8'h01;
      if (ec > m_end) begin
        if (m_pend_v) begin
          m_start = ec; m_end = ec + P + L; m_cmd_wr = m_pend_wr; m_pend_v = 0;
        end else if (pr != 2'b00) begin
          m_start = ec; m_end = ec + P + L; m_cmd_wr = !pr[0];
        end
      end else if (ec > m_start && QUEUE && !m_pend_v && pr != 2'b00) begin
        m_pend_v = 1; m_pend_wr = !pr[0];
      end
    end
    in_pulse = (ec >= m_start) && (ec < m_start + P);
    exp_rd   = !(in_pulse && !m_cmd_wr);
    exp_wr   = !(in_pulse && m_cmd_wr);
    exp_busy = (ec >= m_start) && (ec < m_end);
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_rd, key_wr, busy, data_in} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL reset cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=1 wr=1 busy=0 data=00", i, key_rd, key_wr, busy, data_in);
      end
      if (i == 2) rst = 1'b0;
    end
  endtask

  task automatic test_bounce();
    key_wr_raw = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_rd, key_wr, busy, data_in} !== {1'b1, 1'b1, 1'b0, 8'h00} ||
          {key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
        n_err++;
        $display("FAIL bounce cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=1 wr=1 busy=0 data=00", i, key_rd, key_wr, busy, data_in);
      end
      if (i == 5) key_wr_raw = 1'b1;
    end
  endtask

  task automatic test_single_write();
    int first_low = 0, lows = 0, busies = 0;
    logic [7:0] data_at_fall = 8'hxx;
    logic prev_busy = 1'b0;
    key_wr_raw = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
        n_err++;
        $display("FAIL single_write cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=%b wr=%b busy=%b data=%h", i, key_rd, key_wr, busy, data_in, exp_rd, exp_wr, exp_busy, m_data);
      end
      if (key_wr === 1'b0) begin if (first_low == 0) first_low = i; lows++; end
      if (busy === 1'b1) busies++;
      if (prev_busy && busy === 1'b0) data_at_fall = data_in;
      prev_busy = busy;
      if (i == 40) key_wr_raw = 1'b1;
    end
    n_cmp++;
    if (first_low != 11) begin n_err++; $display("FAIL single_write first_low: got %0d, want 11", first_low); end
    n_cmp++;
    if (lows != 2) begin n_err++; $display("FAIL single_write strobe_width: got %0d, want 2", lows); end
    n_cmp++;
    if (busies != 18) begin n_err++; $display("FAIL single_write busy_len: got %0d, want 18", busies); end
    n_cmp++;
    if (data_at_fall !== 8'h01) begin n_err++; $display("FAIL single_write data_after: got %h, want 01", data_at_fall); end
  endtask

  task automatic test_simultaneous();
    int rd_lows = 0, wr_lows = 0;
    key_rd_raw = 1'b0;
    key_wr_raw = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
        n_err++;
        $display("FAIL simultaneous cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=%b wr=%b busy=%b data=%h", i, key_rd, key_wr, busy, data_in, exp_rd, exp_wr, exp_busy, m_data);
      end
      if (key_rd === 1'b0) rd_lows++;
      if (key_wr === 1'b0) wr_lows++;
      if (i == 30) begin key_rd_raw = 1'b1; key_wr_raw = 1'b1; end
    end
    n_cmp++;
    if (rd_lows != 2 || wr_lows != 0) begin
      n_err++;
      $display("FAIL simultaneous strobes: got rd_lows=%0d wr_lows=%0d, want rd_lows=2 wr_lows=0", rd_lows, wr_lows);
    end
    n_cmp++;
    if (data_in !== 8'h01) begin n_err++; $display("FAIL simultaneous data: got %h, want 01", data_in); end
  endtask

  task automatic test_lock_press();
    int rd_first = 0, busy_fall = 0;
    logic prev_busy = 1'b0;
    key_wr_raw = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
        n_err++;
        $display("FAIL lock_press cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=%b wr=%b busy=%b data=%h", i, key_rd, key_wr, busy, data_in, exp_rd, exp_wr, exp_busy, m_data);
      end
      if (key_rd === 1'b0 && rd_first == 0) rd_first = i;
      if (prev_busy && busy === 1'b0 && busy_fall == 0) busy_fall = i;
      prev_busy = busy;
      if (i == 9)  key_rd_raw = 1'b0;
      if (i == 15) key_wr_raw = 1'b1;
      if (i == 54) key_rd_raw = 1'b1;
    end
    n_cmp++;
    if (busy_fall != 29) begin n_err++; $display("FAIL lock_press busy_fall: got %0d, want 29", busy_fall); end
    n_cmp++;
    if (rd_first != (QUEUE ? 30 : 0)) begin
      n_err++;
      $display("FAIL lock_press rd_start: got %0d, want %0d", rd_first, QUEUE ? 30 : 0);
    end
    n_cmp++;
    if (data_in !== 8'h02) begin n_err++; $display("FAIL lock_press data: got %h, want 02", data_in); end
  endtask

  task automatic test_random();
    int rd_left = 0, wr_left = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
        n_err++;
        $display("FAIL random cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=%b wr=%b busy=%b data=%h", i, key_rd, key_wr, busy, data_in, exp_rd, exp_wr, exp_busy, m_data);
      end
      if (i > 2900) begin
        key_rd_raw = 1'b1; key_wr_raw = 1'b1;
      end else begin
        if (rd_left == 0) begin key_rd_raw = ~key_rd_raw; rd_left = $urandom_range(1, 40); end
        else rd_left--;
        if (wr_left == 0) begin key_wr_raw = ~key_wr_raw; wr_left = $urandom_range(1, 40); end
        else wr_left--;
      end
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    key_wr_raw = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 13) begin
        n_cmp++;
        if ({key_wr, busy, data_in} !== {1'b1, 1'b0, 8'h00}) begin
          n_err++;
          $display("FAIL reset_mid: got wr=%b busy=%b data=%h, want wr=1 busy=0 data=00", key_wr, busy, data_in);
        end
      end else begin
        n_cmp++;
        if ({key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
          n_err++;
          $display("FAIL reset_mid cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=%b wr=%b busy=%b data=%h", i, key_rd, key_wr, busy, data_in, exp_rd, exp_wr, exp_busy, m_data);
        end
      end
      if (i == 12) rst = 1'b1;
      if (i == 13) begin rst = 1'b0; key_wr_raw = 1'b1; end
    end
    for (int w = 1; w <= 256; w++) begin
      key_wr_raw = 1'b0;
      for (int i = 1; i <= 34; i++) begin
        @(negedge clk);
        n_cmp++;
        if ({key_rd, key_wr, busy, data_in} !== {exp_rd, exp_wr, exp_busy, m_data}) begin
          n_err++;
          $display("FAIL wrap write %0d cyc %0d: got rd=%b wr=%b busy=%b data=%h, want rd=%b wr=%b busy=%b data=%h", w, i, key_rd, key_wr, busy, data_in, exp_rd, exp_wr, exp_busy, m_data);
        end
        if (i == 12) key_wr_raw = 1'b1;
      end
      if (w == 255) begin
        n_cmp++;
        if (data_in !== 8'hFF) begin n_err++; $display("FAIL wrap preload: got %h, want ff", data_in); end
      end
    end
    n_cmp++;
    if (data_in !== 8'h00) begin n_err++; $display("FAIL wrap rollover: got %h, want 00", data_in); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_single_write();
    test_simultaneous();
    test_lock_press();
    test_random();
    test_reset_mid_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
